mult_share_arbiter: RTL and testbench

MULT_SHARE_ARBITER -- requirements
Module: mult_share_arbiter

---
 rtl/mult_share_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mult_share_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Shares a single pipelined 24x34 integer multiplier among N_REQ requesters.
// A round-robin arbiter grants at most one requester per cycle. The granted
// operands are registered onto mul_a/mul_b. A tag (valid + requester index)
// travels alongside the operation so that the product coming back on
// mul_result can be routed to the requester that issued it.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-high reset
//   pause       when high, no new grant is issued
//   req_valid   per-requester request strobe            [N_REQ]
//   req_ready   one-hot (or zero) combinational grant   [N_REQ]
//   req_a       packed 24-bit operands, requester i at [24i+23:24i]
//   req_b       packed 34-bit operands, requester i at [34i+33:34i]
//   mul_a/b     registered operands to the multiplier
//   mul_result  multiplier product, MULT_LATENCY cycles after mul_a/mul_b
//   rsp_valid   one-hot (or zero) result strobe, cannot be stalled
//   rsp_result  registered product, zero when rsp_valid is zero
//   inflight    accepted operations whose response has not finished yet
//   busy        inflight != 0
module mult_share_arbiter #(
  parameter int N_REQ        = 4,
  parameter int MULT_LATENCY = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              pause,
  input  logic [N_REQ-1:0]                  req_valid,
  output logic [N_REQ-1:0]                  req_ready,
  input  logic [N_REQ*24-1:0]               req_a,
  input  logic [N_REQ*34-1:0]               req_b,
  output logic [23:0]                       mul_a,
  output logic [33:0]                       mul_b,
  input  logic [57:0]                       mul_result,
  output logic [N_REQ-1:0]                  rsp_valid,
  output logic [57:0]                       rsp_result,
  output logic [$clog2(MULT_LATENCY+3)-1:0] inflight,
  output logic                              busy
);

  localparam int IDX_W = $clog2(N_REQ);
  // Tag pipe stage 0 lines up with mul_a/mul_b; the last stage lines up
  // with the cycle in which mul_result carries that operation's product.
  localparam int DEPTH = MULT_LATENCY + 1;
  localparam int CNT_W = $clog2(MULT_LATENCY + 3);

  logic [IDX_W-1:0]            last_grant_reg;
  logic [IDX_W-1:0]            cand [N_REQ];
  logic [IDX_W-1:0]            grant_idx;
  logic                        grant_found;
  logic                        handshake;
  logic [DEPTH-1:0]            tag_valid_reg;
  logic [DEPTH-1:0][IDX_W-1:0] tag_idx_reg;
  logic [N_REQ-1:0]            tag_onehot;
  logic [CNT_W-1:0]            inflight_reg;
  logic [CNT_W-1:0]            inflight_next;
  logic                        rsp_any;

  // Search order: candidate k is (last_grant + 1 + k) mod N_REQ.
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cand
      localparam int OFS = gi + 1;
      assign cand[gi] = IDX_W'((int'(last_grant_reg) + OFS) % N_REQ);
    end
  endgenerate

  // Grant is gated by rst so req_ready is zero while reset is held.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    req_ready   = '0;
    if (!rst && !pause) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!grant_found && req_valid[cand[k]]) begin
          grant_found = 1'b1;
          grant_idx   = cand[k];
        end
      end
    end
    if (grant_found) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // The grant only ever points at a requester that is valid.
  assign handshake = grant_found;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mul_a          <= '0;
      mul_b          <= '0;
      last_grant_reg <= IDX_W'(N_REQ - 1);
    end else if (handshake) begin
      mul_a          <= req_a[grant_idx*24 +: 24];
      mul_b          <= req_b[grant_idx*34 +: 34];
      last_grant_reg <= grant_idx;
    end else begin
      mul_a <= '0;
      mul_b <= '0;
    end
  end

  // Tag shift register; cleared on reset so products still draining out
  // of the multiplier after a reset are never reported.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid_reg <= '0;
      tag_idx_reg   <= '0;
    end else begin
      tag_valid_reg <= {tag_valid_reg[DEPTH-2:0], handshake};
      tag_idx_reg   <= {tag_idx_reg[DEPTH-2:0], grant_idx};
    end
  end

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_onehot
      assign tag_onehot[gi] = (tag_idx_reg[DEPTH-1] == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_result <= '0;
    end else if (tag_valid_reg[DEPTH-1]) begin
      rsp_valid  <= tag_onehot;
      rsp_result <= mul_result;
    end else begin
      rsp_valid  <= '0;
      rsp_result <= '0;
    end
  end

  // An operation stays counted until the edge that ends its response
  // cycle, so a full pipeline holds MULT_LATENCY+2 operations.
  assign rsp_any = |rsp_valid;

  always_comb begin
    inflight_next = inflight_reg;
    if (handshake && !rsp_any) begin
      inflight_next = inflight_reg + CNT_W'(1);
    end else if (rsp_any && !handshake) begin
      inflight_next = inflight_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_reg <= '0;
    end else begin
      inflight_reg <= inflight_next;
    end
  end

  assign inflight = inflight_reg;
  assign busy     = (inflight_reg != '0);

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int N  = 4;
  localparam int L  = 3;
  localparam int CW = $clog2(L + 3);

  logic            clk = 1'b0;
  logic            rst;
  logic            pause;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*24-1:0] req_a;
  logic [N*34-1:0] req_b;
  logic [23:0]     mul_a;
  logic [33:0]     mul_b;
  logic [57:0]     mul_result;
  logic [N-1:0]    rsp_valid;
  logic [57:0]     rsp_result;
  logic [CW-1:0]   inflight;
  logic            busy;

  mult_share_arbiter #(.N_REQ(N), .MULT_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .pause(pause),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result),
    .inflight(inflight), .busy(busy)
  );

  always #5 clk = ~clk;

  // Multiplier model: product appears L cycles after the operands.
  logic [57:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= 58'(mul_a) * 58'(mul_b);
    for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
  end
  assign mul_result = mpipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit verbose = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          idx;
    logic [57:0] prod;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          grant_log[$];
  int          grant_cyc_log[$];
  int          rsp_idx_log[$];
  logic [57:0] rsp_res_log[$];
  int          rsp_cyc_log[$];
  int          peak = 0;

  // Reference arbiter: predicts req_ready and pushes expected responses.
  int          m_last = N - 1;
  int          m_idx;
  bit          m_found;
  logic [N-1:0] m_ready;
  logic [57:0] m_prod;
  always begin
    @(negedge clk);
    #1;
    m_ready = '0;
    m_found = 1'b0;
    m_idx   = 0;
    if (rst) begin
      exp_q.delete();
      m_last = N - 1;
    end else if (!pause) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_last + 1 + k) % N;
        if (!m_found && req_valid[c]) begin
          m_found = 1'b1;
          m_idx   = c;
        end
      end
    end
    if (m_found) m_ready[m_idx] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(m_ready));
    if (m_found) begin
      m_prod = 58'(req_a[m_idx*24 +: 24]) * 58'(req_b[m_idx*34 +: 34]);
      exp_q.push_back('{idx: m_idx, prod: m_prod, due: cyc + L + 2});
      m_last = m_idx;
    end
  end

  // Monitor: checks counters every cycle and pops on each response.
  int   exp_inf;
  exp_t mon_e;
  int   rsp_i;
  always @(negedge clk) begin
    if (rst) begin
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_result", 64'(rsp_result), 64'd0);
      check("rst_inflight", 64'(inflight), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mul_a", 64'(mul_a), 64'd0);
      check("rst_mul_b", 64'(mul_b), 64'd0);
    end else begin
      exp_inf = 0;
      foreach (exp_q[j]) if (exp_q[j].due - (L + 1) <= cyc) exp_inf++;
      check("inflight", 64'(inflight), 64'(exp_inf));
      check("busy", 64'(busy), 64'(exp_inf != 0));
      if (int'(inflight) > peak) peak = int'(inflight);
      if (rsp_valid != '0) begin
        rsp_i = 0;
        for (int k = 0; k < N; k++) if (rsp_valid[k]) rsp_i = k;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rsp_valid=%0h expected none (cycle %0d)", rsp_valid, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << mon_e.idx));
          check("rsp_result", 64'(rsp_result), 64'(mon_e.prod));
          check("rsp_latency", 64'(cyc), 64'(mon_e.due));
        end
        rsp_idx_log.push_back(rsp_i);
        rsp_res_log.push_back(rsp_result);
        rsp_cyc_log.push_back(cyc);
        if (verbose) $display("rsp cycle %0d req %0d result %0h", cyc, rsp_i, rsp_result);
      end else begin
        check("rsp_result_idle", 64'(rsp_result), 64'd0);
        if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_rsp: got nothing expected req %0d at cycle %0d (cycle %0d)",
                   exp_q[0].idx, exp_q[0].due, cyc);
          void'(exp_q.pop_front());
        end
      end
      if ((req_ready & req_valid) != '0) begin
        for (int k = 0; k < N; k++) begin
          if (req_ready[k] && req_valid[k]) begin
            grant_log.push_back(k);
            grant_cyc_log.push_back(cyc);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [23:0] a, input logic [33:0] b);
    req_a[i*24 +: 24] = a;
    req_b[i*34 +: 34] = b;
  endtask

  task automatic clear_logs();
    grant_log.delete();
    grant_cyc_log.delete();
    rsp_idx_log.delete();
    rsp_res_log.delete();
    rsp_cyc_log.delete();
  endtask

  int pause_start;

  initial begin
    rst       = 1'b1;
    pause     = 1'b0;
    req_valid = '1;   // grant must stay zero while reset is held
    req_a     = '0;
    req_b     = '0;
    step(3);
    rst       = 1'b0;
    req_valid = '0;
    step(2);

    // All requesters contend for 8 cycles: requester 0 has first priority.
    clear_logs();
    for (int i = 0; i < N; i++) set_op(i, 24'(i + 1), 34'(100 + i));
    req_valid = '1;
    step(8);
    req_valid = '0;
    step(L + 6);
    check("contend_grants", 64'(grant_log.size()), 64'd8);
    check("contend_rsps", 64'(rsp_idx_log.size()), 64'd8);
    for (int i = 0; i < 8 && i < grant_log.size() && i < rsp_idx_log.size(); i++) begin
      check("contend_grant_order", 64'(grant_log[i]), 64'(i % 4));
      check("contend_rsp_order", 64'(rsp_idx_log[i]), 64'(i % 4));
      check("contend_rsp_gapless", 64'(rsp_cyc_log[i] - rsp_cyc_log[0]), 64'(i));
    end

    // Single request, largest operands:
    // (2^24-1)(2^34-1) = 2^58 - 2^34 - 2^24 + 1 = 58'h3FFFFFBFF000001.
    clear_logs();
    set_op(2, 24'hFFFFFF, 34'h3FFFFFFFF);
    req_valid = 4'b0100;
    step(1);
    req_valid = '0;
    step(L + 6);
    check("single_rsps", 64'(rsp_idx_log.size()), 64'd1);
    if (rsp_idx_log.size() == 1 && grant_cyc_log.size() == 1) begin
      check("single_idx", 64'(rsp_idx_log[0]), 64'd2);
      check("single_result", 64'(rsp_res_log[0]), 64'h3FFFFFBFF000001);
      check("single_latency", 64'(rsp_cyc_log[0] - grant_cyc_log[0]), 64'(L + 2));
    end
    @(negedge clk);
    check("single_inflight_idle", 64'(inflight), 64'd0);
    step(1);

    // Back-to-back from requester 1, then pause with everyone requesting.
    clear_logs();
    peak = 0;
    for (int k = 0; k < 10; k++) begin
      set_op(1, 24'd3, 34'(k));
      req_valid = 4'b0010;
      step(1);
    end
    for (int i = 0; i < N; i++) set_op(i, 24'(7 + i), 34'(11 + i));
    req_valid   = '1;
    pause       = 1'b1;
    pause_start = cyc;
    step(5);
    pause = 1'b0;
    step(1);
    req_valid = '0;
    step(L + 6);
    check("b2b_peak", 64'(peak), 64'(L + 2));
    check("pause_grants", 64'(grant_log.size()), 64'd11);
    check("pause_rsps", 64'(rsp_idx_log.size()), 64'd11);
    if (rsp_idx_log.size() == 11 && grant_log.size() == 11) begin
      for (int k = 0; k < 10; k++) begin
        check("b2b_idx", 64'(rsp_idx_log[k]), 64'd1);
        check("b2b_result", 64'(rsp_res_log[k]), 64'(3 * k));
        check("b2b_gapless", 64'(rsp_cyc_log[k] - rsp_cyc_log[0]), 64'(k));
      end
      check("pause_drain_during_pause", 64'(rsp_cyc_log[9] > pause_start), 64'd1);
      check("pause_first_grant", 64'(grant_log[10]), 64'd2);
      check("pause_rsp_idx", 64'(rsp_idx_log[10]), 64'd2);
      check("pause_rsp_result", 64'(rsp_res_log[10]), 64'(9 * 13));
    end

    // Reset with three operations outstanding.
    clear_logs();
    for (int i = 0; i < N; i++) set_op(i, 24'(20 + i), 34'(30 + i));
    req_valid = '1;
    step(3);
    rst       = 1'b1;
    req_valid = '0;
    step(2);
    rst = 1'b0;
    step(L + 6);
    check("rst_grants_before", 64'(grant_log.size()), 64'd3);
    check("rst_no_rsp", 64'(rsp_idx_log.size()), 64'd0);
    @(negedge clk);
    check("rst_inflight_after", 64'(inflight), 64'd0);
    step(1);
    clear_logs();
    req_valid = '1;
    step(1);
    req_valid = '0;
    step(L + 6);
    check("rst_next_grants", 64'(grant_log.size()), 64'd1);
    if (grant_log.size() == 1) check("rst_next_grant", 64'(grant_log[0]), 64'd0);
    check("rst_next_rsps", 64'(rsp_idx_log.size()), 64'd1);

    // Random traffic against the reference model.
    verbose = 1'b0;
    for (int t = 0; t < 10000; t++) begin
      req_valid = N'($urandom);
      pause     = ($urandom_range(0, 7) == 0);
      for (int i = 0; i < N; i++) set_op(i, 24'($urandom), {2'($urandom), 32'($urandom)});
      step(1);
    end
    req_valid = '0;
    pause     = 1'b0;
    step(L + 6);
    check("random_drained", 64'(exp_q.size()), 64'd0);
    verbose = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
